rtc_bus_sequencer: RTL and testbench
====================================

Name: rtc_bus_sequencer

Overview:
- Transaction controller for the external parallel RTC chip on a multiplexed address/data bus.
- Accepts single-byte read or write requests from the RTC front-end logic.
- Sequences each request through four fixed-length timing phases: address, gap, data, recovery.
- Drives chip strobes and bus direction, captures read data, and reports completion with a one-cycle pulse.

Parameters:
- PHASE_CLKS, 32, clock cycles per bus phase; legal range 2..64.
- CW, 6, phase-counter width; must satisfy 2^CW >= PHASE_CLKS.

Ports:
- clk      in   1  system clock
- reset    in   1  reset, asynchronous, active-high
- req      in   1  transaction request; sampled only while busy=0
- we       in   1  1 = write, 0 = read; latched with req
- addr     in   8  RTC register address; latched with req
- wdata    in   8  write byte; latched with req
- busy     out  1  transaction in progress
- done     out  1  one-cycle completion pulse
- rdata    out  8  last byte read; held until the next read completes
- cs_n     out  1  chip select, active-low
- rd_n     out  1  read strobe, active-low
- wr_n     out  1  write strobe, active-low
- ad_n     out  1  0 = address cycle, 1 = data cycle
- ad_out   out  8  bus drive value
- ad_oe    out  1  bus output enable; 1 = drive ad_out
- ad_in    in   8  bus sample value

Behaviour:
- All outputs are registered.
- Reset values: busy=0, done=0, rdata=0x00, cs_n=1, rd_n=1, wr_n=1, ad_n=1, ad_out=0x00, ad_oe=0. Internal state = IDLE, phase count = 0.
- States: IDLE, ADDR, GAP, DATA, RECOV.
- Phase counter: cleared on every state entry; increments each clock in a non-IDLE state. The state advances at the edge where count == PHASE_CLKS-1, so each non-IDLE state lasts exactly PHASE_CLKS cycles.
- Accept: at a clock edge where state is IDLE and req=1:
  - latch we, addr and wdata;
  - enter ADDR and set busy=1 at that same edge.
- Requests seen while busy=1 are ignored, not queued.
- ADDR:
  - cs_n=0, ad_n=0, wr_n=0, rd_n=1, ad_oe=1, ad_out=addr (latched).
  - The address is written in this phase for both reads and writes.
- GAP: cs_n=1, rd_n=1, wr_n=1, ad_n=1, ad_oe=0. Bus is released.
- DATA, write (we=1): cs_n=0, ad_n=1, wr_n=0, ad_oe=1, ad_out=wdata (latched).
- DATA, read (we=0):
  - cs_n=0, ad_n=1, rd_n=0, ad_oe=0.
  - rdata <= ad_in at the edge that ends DATA (the final DATA cycle).
- RECOV: all strobes high, ad_oe=0.
- Completion: at the edge ending RECOV, state returns to IDLE, busy=0 and done=1 for exactly one cycle.
  - Latency: done rises 4*PHASE_CLKS clocks after the accept edge.
- Back-to-back: req=1 in the cycle where done=1 is accepted at the next edge. That gives one IDLE cycle between transactions.
- ad_out changes only when ad_oe changes or at a phase boundary. There is never a same-cycle drive conflict: ad_oe=0 whenever rd_n=0.
- Writes leave rdata unchanged.
- Reset asserted mid-transaction:
  - all strobes go high and ad_oe goes to 0 immediately (asynchronous);
  - state returns to IDLE and no done pulse is produced;
  - rdata is cleared to 0x00.
- Release from reset: the first accept is possible at the first clock edge after reset deasserts.

Test Plan:
1. Write, PHASE_CLKS=32, addr=0x21, wdata=0x45:
   - cs_n=0 and wr_n=0 for cycles 0-31 (ad_n=0, ad_out=0x21) and cycles 64-95 (ad_n=1, ad_out=0x45);
   - all strobes high for cycles 32-63 and 96-127;
   - done=1 at cycle 128; rdata unchanged.
2. Read, addr=0x22, bench drives ad_in=0x37 during cycles 64-95:
   - ad_oe=0 and rd_n=0 for cycles 64-95; wr_n=1 throughout the data phase;
   - rdata=0x37 from cycle 96 onward; done at cycle 128.
3. Request while busy: pulse req with addr=0x55 at cycle 40 of a write.
   - Ignored; only one done pulse; the next transaction still uses the original latched addr/wdata.
4. Back-to-back: req held high across two reads (0x10, then 0x11).
   - Second ADDR starts exactly one cycle after the first done pulse; each read captures its own ad_in value.
5. Reset at cycle 70 of a write:
   - cs_n, wr_n and ad_n go to 1 and ad_oe to 0 within the same cycle;
   - no done pulse; a new request after reset completes normally.
6. PHASE_CLKS=2 read:
   - each phase lasts 2 cycles; done at cycle 8;
   - rdata equals the ad_in value present at cycle 5.

Source files
------------

// File: rtl/rtc_bus_sequencer_if.sv
// Front-end request/response signals and multiplexed RTC bus pins for rtc_bus_sequencer.
// ad_in is the sampled pad value, so it is driven from outside the sequencer like the request fields.
interface rtc_bus_sequencer_if;
    logic       req;
    logic       we;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic       busy;
    logic       done;
    logic [7:0] rdata;
    logic       cs_n;
    logic       rd_n;
    logic       wr_n;
    logic       ad_n;
    logic [7:0] ad_out;
    logic       ad_oe;
    logic [7:0] ad_in;

    modport master (
        output req, we, addr, wdata, ad_in,
        input  busy, done, rdata, cs_n, rd_n, wr_n, ad_n, ad_out, ad_oe
    );

    modport slave (
        input  req, we, addr, wdata, ad_in,
        output busy, done, rdata, cs_n, rd_n, wr_n, ad_n, ad_out, ad_oe
    );
endinterface

// File: rtl/rtc_bus_sequencer.sv
// Single-byte transaction sequencer for the external parallel RTC on a multiplexed A/D bus.
// Every request runs address, gap, data and recovery phases of PHASE_CLKS cycles each.
module rtc_bus_sequencer #(
    parameter int unsigned PHASE_CLKS = 32,
    parameter int unsigned CW         = 6
) (
    input  logic               clk,
    input  logic               reset,
    rtc_bus_sequencer_if.slave bus
);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] ADDR  = 3'd1;
    localparam logic [2:0] GAP   = 3'd2;
    localparam logic [2:0] DATA  = 3'd3;
    localparam logic [2:0] RECOV = 3'd4;

    localparam logic [CW-1:0] LAST = CW'(PHASE_CLKS - 1);

    logic [2:0]    state_q,  state_d;
    logic [CW-1:0] cnt_q,    cnt_d;
    logic          we_q,     we_d;
    logic [7:0]    addr_q,   addr_d;
    logic [7:0]    wdata_q,  wdata_d;
    logic          busy_q,   busy_d;
    logic          done_q,   done_d;
    logic [7:0]    rdata_q,  rdata_d;
    logic          cs_n_q,   cs_n_d;
    logic          rd_n_q,   rd_n_d;
    logic          wr_n_q,   wr_n_d;
    logic          ad_n_q,   ad_n_d;
    logic [7:0]    ad_out_q, ad_out_d;
    logic          ad_oe_q,  ad_oe_d;

    // Sequencing: next state, phase counter, request latch and read capture.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        rdata_d = rdata_q;

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (bus.req) begin
                    state_d = ADDR;
                    we_d    = bus.we;
                    addr_d  = bus.addr;
                    wdata_d = bus.wdata;
                    busy_d  = 1'b1;
                end
            end
            ADDR, GAP, DATA, RECOV: begin
                if (cnt_q == LAST) begin
                    cnt_d = '0;
                    case (state_q)
                        ADDR:    state_d = GAP;
                        GAP:     state_d = DATA;
                        DATA: begin
                            state_d = RECOV;
                            if (!we_q) begin
                                rdata_d = bus.ad_in;
                            end
                        end
                        default: begin
                            state_d = IDLE;
                            busy_d  = 1'b0;
                            done_d  = 1'b1;
                        end
                    endcase
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                busy_d  = 1'b0;
            end
        endcase
    end

    // Bus pins are decoded from the next state so they stay registered and switch on phase edges.
    always_comb begin
        cs_n_d   = 1'b1;
        rd_n_d   = 1'b1;
        wr_n_d   = 1'b1;
        ad_n_d   = 1'b1;
        ad_oe_d  = 1'b0;
        ad_out_d = ad_out_q;

        case (state_d)
            ADDR: begin
                cs_n_d   = 1'b0;
                ad_n_d   = 1'b0;
                wr_n_d   = 1'b0;
                ad_oe_d  = 1'b1;
                ad_out_d = addr_d;
            end
            DATA: begin
                cs_n_d = 1'b0;
                if (we_d) begin
                    wr_n_d   = 1'b0;
                    ad_oe_d  = 1'b1;
                    ad_out_d = wdata_d;
                end else begin
                    rd_n_d = 1'b0;
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            rdata_q  <= '0;
            cs_n_q   <= 1'b1;
            rd_n_q   <= 1'b1;
            wr_n_q   <= 1'b1;
            ad_n_q   <= 1'b1;
            ad_out_q <= '0;
            ad_oe_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            rdata_q  <= rdata_d;
            cs_n_q   <= cs_n_d;
            rd_n_q   <= rd_n_d;
            wr_n_q   <= wr_n_d;
            ad_n_q   <= ad_n_d;
            ad_out_q <= ad_out_d;
            ad_oe_q  <= ad_oe_d;
        end
    end

    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.rdata  = rdata_q;
    assign bus.cs_n   = cs_n_q;
    assign bus.rd_n   = rd_n_q;
    assign bus.wr_n   = wr_n_q;
    assign bus.ad_n   = ad_n_q;
    assign bus.ad_out = ad_out_q;
    assign bus.ad_oe  = ad_oe_q;

endmodule

// File: tb/tb_rtc_bus_sequencer.sv
// Bench for rtc_bus_sequencer: a 32-cycle-phase and a 2-cycle-phase instance checked every
// cycle against a transaction-level model, plus directed literal checks.
module tb_rtc_bus_sequencer;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    rtc_bus_sequencer_if bi32 ();
    rtc_bus_sequencer_if bi2 ();

    rtc_bus_sequencer #(.PHASE_CLKS(32), .CW(6)) dut32 (.clk(clk), .reset(reset), .bus(bi32.slave));
    rtc_bus_sequencer #(.PHASE_CLKS(2),  .CW(2)) dut2  (.clk(clk), .reset(reset), .bus(bi2.slave));

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    typedef struct {
        bit         active;
        int         t;
        bit         we;
        logic [7:0] addr;
        logic [7:0] wdata;
        logic [7:0] rdata;
        bit         done;
    } model_t;

    model_t m32, m2;

    function automatic model_t reset_model();
        model_t s;
        s.active = 0; s.t = 0; s.we = 0;
        s.addr = 8'h00; s.wdata = 8'h00; s.rdata = 8'h00; s.done = 0;
        return s;
    endfunction

    // t counts cycles since the accept edge; a transaction spans t = 0 .. 4p-1.
    function automatic model_t step(model_t s, int p, logic req, logic we,
                                    logic [7:0] addr, logic [7:0] wdata, logic [7:0] ad_in);
        model_t n = s;
        n.done = 0;
        if (!s.active) begin
            if (req) begin
                n.active = 1; n.t = 0; n.we = we; n.addr = addr; n.wdata = wdata;
            end
        end else begin
            if (s.t == 3*p - 1 && !s.we) n.rdata = ad_in;
            n.t = s.t + 1;
            if (n.t == 4*p) begin
                n.active = 0;
                n.done   = 1;
            end
        end
        return n;
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m32 <= reset_model();
            m2  <= reset_model();
        end else begin
            m32 <= step(m32, 32, bi32.req, bi32.we, bi32.addr, bi32.wdata, bi32.ad_in);
            m2  <= step(m2,  2,  bi2.req,  bi2.we,  bi2.addr,  bi2.wdata,  bi2.ad_in);
        end
    end

    task automatic chk(string name, logic [7:0] act, logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    task automatic check_dut(string tag, model_t s, int p, logic busy, logic done,
                             logic [7:0] rdata, logic cs_n, logic rd_n, logic wr_n,
                             logic ad_n, logic [7:0] ad_out, logic ad_oe);
        int ph;
        logic ecs, erd, ewr, ead, eoe;
        logic [7:0] eout;
        ecs = 1; erd = 1; ewr = 1; ead = 1; eoe = 0; eout = 8'h00;
        ph = s.active ? s.t / p : -1;
        if (ph == 0) begin
            ecs = 0; ead = 0; ewr = 0; eoe = 1; eout = s.addr;
        end else if (ph == 2) begin
            ecs = 0;
            if (s.we) begin ewr = 0; eoe = 1; eout = s.wdata; end
            else erd = 0;
        end
        chk({tag, ".busy"},  busy,  s.active);
        chk({tag, ".done"},  done,  s.done);
        chk({tag, ".rdata"}, rdata, s.rdata);
        chk({tag, ".cs_n"},  cs_n,  ecs);
        chk({tag, ".rd_n"},  rd_n,  erd);
        chk({tag, ".wr_n"},  wr_n,  ewr);
        chk({tag, ".ad_n"},  ad_n,  ead);
        chk({tag, ".ad_oe"}, ad_oe, eoe);
        if (eoe) chk({tag, ".ad_out"}, ad_out, eout);
        chk({tag, ".oe_while_rd"}, ad_oe & ~rd_n, 1'b0);
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            check_dut("d32", m32, 32, bi32.busy, bi32.done, bi32.rdata, bi32.cs_n, bi32.rd_n,
                      bi32.wr_n, bi32.ad_n, bi32.ad_out, bi32.ad_oe);
            check_dut("d2", m2, 2, bi2.busy, bi2.done, bi2.rdata, bi2.cs_n, bi2.rd_n,
                      bi2.wr_n, bi2.ad_n, bi2.ad_out, bi2.ad_oe);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic goto(int c);
        while (cyc < c) tick();
    endtask

    task automatic start32(logic [7:0] a, logic [7:0] w, logic we_i, bit hold);
        @(negedge clk);
        bi32.req = 1; bi32.we = we_i; bi32.addr = a; bi32.wdata = w;
        @(posedge clk);
        #1;
        cyc = 0;
        if (!hold) begin
            @(negedge clk);
            bi32.req = 0;
        end
    endtask

    initial begin
        reset = 1;
        bi32.req = 0; bi32.we = 0; bi32.addr = 0; bi32.wdata = 0; bi32.ad_in = 0;
        bi2.req  = 0; bi2.we  = 0; bi2.addr  = 0; bi2.wdata  = 0; bi2.ad_in  = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst.busy", bi32.busy, 1'b0);   chk("rst.done", bi32.done, 1'b0);
        chk("rst.rdata", bi32.rdata, 8'h00); chk("rst.cs_n", bi32.cs_n, 1'b1);
        chk("rst.rd_n", bi32.rd_n, 1'b1);   chk("rst.wr_n", bi32.wr_n, 1'b1);
        chk("rst.ad_n", bi32.ad_n, 1'b1);   chk("rst.ad_out", bi32.ad_out, 8'h00);
        chk("rst.ad_oe", bi32.ad_oe, 1'b0);
        @(negedge clk);
        reset = 0;

        // Write 0x45 to 0x21
        start32(8'h21, 8'h45, 1'b1, 1'b0);
        chk("t1.c0.cs_n", bi32.cs_n, 1'b0); chk("t1.c0.wr_n", bi32.wr_n, 1'b0);
        chk("t1.c0.ad_n", bi32.ad_n, 1'b0); chk("t1.c0.ad_out", bi32.ad_out, 8'h21);
        goto(31); chk("t1.c31.cs_n", bi32.cs_n, 1'b0);
        goto(32); chk("t1.c32.cs_n", bi32.cs_n, 1'b1); chk("t1.c32.wr_n", bi32.wr_n, 1'b1);
        goto(64); chk("t1.c64.ad_out", bi32.ad_out, 8'h45); chk("t1.c64.ad_n", bi32.ad_n, 1'b1);
        chk("t1.c64.wr_n", bi32.wr_n, 1'b0);
        goto(96); chk("t1.c96.cs_n", bi32.cs_n, 1'b1);
        goto(127); chk("t1.c127.done", bi32.done, 1'b0); chk("t1.c127.busy", bi32.busy, 1'b1);
        goto(128); chk("t1.c128.done", bi32.done, 1'b1); chk("t1.c128.busy", bi32.busy, 1'b0);
        chk("t1.rdata", bi32.rdata, 8'h00);
        goto(129); chk("t1.c129.done", bi32.done, 1'b0);

        // Read 0x22, chip returns 0x37
        start32(8'h22, 8'h00, 1'b0, 1'b0);
        goto(64); @(negedge clk); bi32.ad_in = 8'h37;
        goto(70); chk("t2.rd_n", bi32.rd_n, 1'b0); chk("t2.ad_oe", bi32.ad_oe, 1'b0);
        chk("t2.wr_n", bi32.wr_n, 1'b1);
        goto(95); chk("t2.c95.rdata", bi32.rdata, 8'h00);
        goto(96); chk("t2.c96.rdata", bi32.rdata, 8'h37);
        @(negedge clk); bi32.ad_in = 8'h00;
        goto(128); chk("t2.done", bi32.done, 1'b1);

        // Request while busy is dropped
        start32(8'h33, 8'h99, 1'b1, 1'b0);
        goto(40); @(negedge clk);
        bi32.req = 1; bi32.we = 0; bi32.addr = 8'h55; bi32.wdata = 8'hAA;
        goto(41); @(negedge clk); bi32.req = 0;
        goto(64); chk("t3.ad_out", bi32.ad_out, 8'h99);
        goto(128); chk("t3.done", bi32.done, 1'b1);
        goto(140); chk("t3.idle", bi32.busy, 1'b0);

        // Back-to-back reads with req held high
        start32(8'h10, 8'h00, 1'b0, 1'b1);
        goto(64); @(negedge clk); bi32.ad_in = 8'h5A;
        goto(96); chk("t4a.rdata", bi32.rdata, 8'h5A);
        @(negedge clk); bi32.ad_in = 8'h00;
        goto(128); chk("t4a.done", bi32.done, 1'b1);
        @(negedge clk); bi32.addr = 8'h11;
        goto(129); chk("t4b.busy", bi32.busy, 1'b1); chk("t4b.ad_out", bi32.ad_out, 8'h11);
        chk("t4b.cs_n", bi32.cs_n, 1'b0);
        cyc = 0;
        @(negedge clk); bi32.req = 0;
        goto(64); @(negedge clk); bi32.ad_in = 8'hA5;
        goto(96); chk("t4b.rdata", bi32.rdata, 8'hA5);
        @(negedge clk); bi32.ad_in = 8'h00;
        goto(128); chk("t4b.done", bi32.done, 1'b1);

        // Reset in the data phase of a write
        start32(8'h66, 8'h77, 1'b1, 1'b0);
        goto(70); chk("t5.pre.wr_n", bi32.wr_n, 1'b0); chk("t5.pre.rdata", bi32.rdata, 8'hA5);
        #2 reset = 1;
        #1;
        chk("t5.cs_n", bi32.cs_n, 1'b1); chk("t5.wr_n", bi32.wr_n, 1'b1);
        chk("t5.ad_n", bi32.ad_n, 1'b1); chk("t5.ad_oe", bi32.ad_oe, 1'b0);
        chk("t5.busy", bi32.busy, 1'b0); chk("t5.rdata", bi32.rdata, 8'h00);
        @(posedge clk);
        #1;
        @(negedge clk);
        reset = 0;
        bi32.req = 1; bi32.we = 0; bi32.addr = 8'h44;
        @(posedge clk);
        #1;
        cyc = 0;
        chk("t5.new.busy", bi32.busy, 1'b1); chk("t5.new.ad_out", bi32.ad_out, 8'h44);
        @(negedge clk); bi32.req = 0;
        goto(64); @(negedge clk); bi32.ad_in = 8'h3C;
        goto(96); chk("t5.new.rdata", bi32.rdata, 8'h3C);
        goto(128); chk("t5.new.done", bi32.done, 1'b1);

        // Shortest phase length
        @(negedge clk);
        bi2.req = 1; bi2.we = 0; bi2.addr = 8'h0F;
        @(posedge clk);
        #1;
        cyc = 0;
        chk("t6.c0.cs_n", bi2.cs_n, 1'b0); chk("t6.c0.ad_out", bi2.ad_out, 8'h0F);
        @(negedge clk); bi2.req = 0;
        goto(2); chk("t6.c2.cs_n", bi2.cs_n, 1'b1);
        goto(4); chk("t6.c4.rd_n", bi2.rd_n, 1'b0);
        @(negedge clk); bi2.ad_in = 8'h11;
        goto(5); @(negedge clk); bi2.ad_in = 8'h5C;
        goto(6); chk("t6.c6.rdata", bi2.rdata, 8'h5C);
        @(negedge clk); bi2.ad_in = 8'h99;
        goto(7); chk("t6.c7.done", bi2.done, 1'b0);
        goto(8); chk("t6.c8.done", bi2.done, 1'b1); chk("t6.c8.busy", bi2.busy, 1'b0);
        goto(9); chk("t6.c9.done", bi2.done, 1'b0); chk("t6.c9.rdata", bi2.rdata, 8'h5C);

        repeat (3) tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
